// File: rtl/alu_exec_wb.sv
// alu_exec_wb: execute/writeback stage behind the ALU issue slot.
// Computes the ALU result, drives the bypass bus and queues writebacks.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   issue_done         one-cycle pulse, ex_type_in/rd_in/operands valid
//   ex_type_in         operation select (0..10 legal)
//   rd_in              destination register
//   operand1/operand2  sources A/B
//   wb_ready           register-file port accepts the head entry
//   wb_valid           FIFO non-empty
//   wb_rd, wb_data     head entry {rd, result}
//   fwd_data, fwd_rd   bypass word {valid, result} and its destination
//   alu_full           FIFO holds DEPTH entries
//   illegal_op         sticky: undefined ex_type executed
//   overflow           sticky: capture dropped on full FIFO
module alu_exec_wb #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_done,
  input  logic [5:0]  ex_type_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        wb_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [32:0] fwd_data,
  output logic [4:0]  fwd_rd,
  output logic        alu_full,
  output logic        illegal_op,
  output logic        overflow
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [4:0]       rd_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] result;
  logic        illegal;
  logic        pop;
  logic        push;
  logic        drop;
  logic [4:0]  sh;

  assign sh = operand2[4:0];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (ex_type_in)
      6'd0:  result = operand1 + operand2;
      6'd1:  result = operand1 - operand2;
      6'd2:  result = operand1 & operand2;
      6'd3:  result = operand1 | operand2;
      6'd4:  result = operand1 ^ operand2;
      6'd5:  result = operand1 << sh;
      6'd6:  result = operand1 >> sh;
      6'd7:  result = $unsigned($signed(operand1) >>> sh);
      6'd8:  result = {31'd0, $signed(operand1) < $signed(operand2)};
      6'd9:  result = {31'd0, operand1 < operand2};
      6'd10: result = operand2;
      default: illegal = 1'b1;
    endcase
  end

  assign wb_valid = (count != '0);
  assign alu_full = (count == FULL_CNT);
  assign wb_rd    = rd_mem[rd_ptr];
  assign wb_data  = data_mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves this cycle.
  assign pop  = wb_valid & wb_ready;
  assign push = issue_done & (rd_in != 5'd0) & (~alu_full | pop);
  assign drop = issue_done & (rd_in != 5'd0) & alu_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_data   <= '0;
      fwd_rd     <= '0;
      illegal_op <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (issue_done) begin
        fwd_data <= {1'b1, result};
        fwd_rd   <= rd_in;
      end else begin
        fwd_data[32] <= 1'b0;
      end
      if (issue_done && illegal) illegal_op <= 1'b1;
      if (drop) overflow <= 1'b1;
      if (push) begin
        rd_mem[wr_ptr]   <= rd_in;
        data_mem[wr_ptr] <= result;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_wb.md
Name: alu_exec_wb

Overview:
- Execute and writeback stage directly downstream of the ALU issue slot.
- On the issue slot's one-cycle done pulse, it captures ex_type, rd and both 32-bit operands, and computes the ALU result.
- It places a 33-bit forwarding word (bit 32 = valid) on a bypass bus and queues {rd, result} in a small FIFO.
- The FIFO drains to the register-file write port under a valid/ready handshake.

Parameters:
- DEPTH, 2, result FIFO entries; power of two, at least 2.
- PTR_W, 1, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- issue_done  input  1  one-cycle pulse; operands, ex_type and rd are valid this cycle
- ex_type_in  input  6  operation select
- rd_in  input  5  destination register
- operand1  input  32  source A
- operand2  input  32  source B
- wb_ready  input  1  register-file port accepts the head entry this cycle
- wb_valid  output  1  FIFO non-empty
- wb_rd  output  5  head entry destination
- wb_data  output  32  head entry result
- fwd_data  output  33  bypass word {valid, result}; bit 32 is high for exactly one cycle
- fwd_rd  output  5  destination matching fwd_data
- alu_full  output  1  FIFO count == DEPTH; dispatch must not load the issue slot while high
- illegal_op  output  1  sticky: an undefined ex_type was executed
- overflow  output  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Reset: on rst=1 at a clock edge, all outputs go to 0 and the FIFO pointers and count go to 0. Reset mid-drain discards every entry, and wb_valid is 0 on the next cycle.
- Opcodes (ex_type_in, result is 32 bits):
  - 0 ADD, 1 SUB (wrap modulo 2^32)
  - 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = operand2[4:0])
  - 8 SLT (signed), 9 SLTU (unsigned); result is 0 or 1
  - 10 PASSB (result = operand2, used for LUI)
  - 11..63: result 0, illegal_op set.
- Result path: the result is combinational from the inputs and registered at the edge ending the issue_done cycle (cycle N).
- Forward path:
  - In cycle N+1: fwd_data = {1'b1, result}, fwd_rd = rd_in.
  - Otherwise fwd_data[32] = 0, and fwd_data[31:0]/fwd_rd hold their last value.
  - Forwarding happens even when rd_in = 0 and even when the capture is dropped.
- Enqueue:
  - Occurs on issue_done when rd_in != 0 and either count < DEPTH, or count == DEPTH with a dequeue in the same cycle.
  - rd_in == 0: nothing is enqueued and no flag is raised (writes to x0 are discarded).
  - issue_done with rd_in != 0 while full and wb_ready = 0: the entry is dropped, overflow is set, and the FIFO is unchanged.
- Dequeue: occurs when wb_valid & wb_ready. wb_rd and wb_data show the head entry combinationally from the FIFO storage.
- Latency: with the FIFO empty, wb_valid rises in cycle N+1 with that entry. With wb_ready held at 1, it is a single-cycle pulse.
- Simultaneous push and pop:
  - Count is unchanged.
  - The new entry goes to the tail, behind the surviving entries.
  - At count == 1 the popped head is replaced next cycle by the new entry.
- Ordering: strict FIFO; pointers wrap modulo DEPTH.
- Handshake: wb_valid never drops while wb_ready is low, and the head entry is stable until accepted.
- Sticky flags: illegal_op and overflow clear only on rst.
- alu_full is registered state (count == DEPTH), valid from the cycle after the filling push.

Test Plan:
- Basic ADD: rst, then issue_done with ex_type=0, rd=5, op1=0x0000_0007, op2=0x0000_0003, wb_ready=1 -> cycle N+1: fwd_data=0x1_0000_000A, fwd_rd=5, wb_valid=1, wb_rd=5, wb_data=0x0000_000A; cycle N+2: wb_valid=0.
- Opcode sweep: op1=0x8000_0000, op2=0x0000_0001.
  - Expected results: SUB 0x7FFF_FFFF; SRA 0xC000_0000; SRL 0x4000_0000; SLT 1; SLTU 0.
  - ex_type=20 -> wb_data=0, illegal_op=1 and it stays 1 thereafter.
- Backpressure and fill: wb_ready=0, three issue_done pulses with rd=1,2,3.
  - After the 2nd push, alu_full=1.
  - The 3rd is dropped: overflow=1, and fwd_data still pulses with the 3rd result.
  - Then wb_ready=1 -> rd 1 then rd 2 drain on consecutive cycles, then wb_valid=0.
- Full with simultaneous pop: FIFO full (rd=1,2), issue_done rd=3 with wb_ready=1 -> no overflow, count stays 2, and drain order is 2 then 3.
- x0 destination: issue_done with rd=0, ADD 4+4 -> fwd_data=0x1_0000_0008 and fwd_rd=0 in N+1; wb_valid stays 0.
- Reset mid-operation: FIFO holding 2 entries, overflow=1; assert rst for one cycle -> next cycle wb_valid=0, alu_full=0, overflow=0, fwd_data=0.
